router_out_arb: RTL and testbench

Wormhole output-port arbiter for the sensor-network router. Shares one output flit channel among N_PORTS input channels using valid/ready handshakes. It grants whole packets in round-robin order and holds the grant from head flit to tail flit. A one-entry registered output stage sits between the arbiter and the downstream link.

---
 rtl/router_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/router_out_arb.sv | 156 +++++++++++++++
 tb/tb_router_out_arb.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/router_arb_pkg.sv
// rtl/router_arb_pkg.sv - shared types and flit-field constants for the router output arbiter
package router_arb_pkg;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // The flit type lives in the top TYPE_W bits of every flit.
  localparam int TYPE_W = 2;

  function automatic int type_lsb(input int flit_w);
    return flit_w - TYPE_W;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, scans upward from ptr_i with wrap
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr_i) + i) % N;
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/router_out_arb.sv
// rtl/router_out_arb.sv - wormhole output-port arbiter: packet-granular round robin,
// one-entry registered output stage, packet counter and sticky protocol error
module router_out_arb
  import router_arb_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int FLIT_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS*FLIT_W-1:0] in_flit_i,
  input  logic [N_PORTS-1:0]        in_vld_i,
  output logic [N_PORTS-1:0]        in_rdy_o,
  output logic [FLIT_W-1:0]         out_flit_o,
  output logic                      out_vld_o,
  input  logic                      out_rdy_i,
  output logic [N_PORTS-1:0]        grant_o,
  output logic [CNT_W-1:0]          pkt_cnt_o,
  output logic                      err_o
);

  localparam int IDX_W    = $clog2(N_PORTS);
  localparam int TYPE_LSB = type_lsb(FLIT_W);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [FLIT_W-1:0] out_flit_q, out_flit_d;
  logic              out_vld_q, out_vld_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic              err_q, err_d;

  flit_type_e        ftype [N_PORTS];
  logic [N_PORTS-1:0] cand, stray;
  logic [N_PORTS-1:0] win_gnt;
  logic [IDX_W-1:0]  win_idx;
  logic              win_any;

  logic              space, load, drain;
  logic [IDX_W-1:0]  sel_idx;
  logic [FLIT_W-1:0] sel_flit;
  flit_type_e        sel_type;

  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] i);
    return (int'(i) == N_PORTS - 1) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    cand  = '0;
    stray = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      ftype[p] = flit_type_e'(in_flit_i[p*FLIT_W + TYPE_LSB +: TYPE_W]);
      cand[p]  = in_vld_i[p] && (ftype[p] == FT_HEAD || ftype[p] == FT_SINGLE);
      stray[p] = in_vld_i[p] && (ftype[p] == FT_BODY || ftype[p] == FT_TAIL);
    end
  end

  rr_arbiter #(
    .N     (N_PORTS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i (cand),
    .ptr_i (rr_ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  // Handshake outputs; held low during reset so upstream never loses a flit.
  always_comb begin
    space    = !out_vld_q || out_rdy_i;
    in_rdy_o = '0;
    grant_o  = '0;
    sel_idx  = owner_q;
    if (!rst) begin
      if (state_q == ST_LOCKED) begin
        grant_o = N_PORTS'(1) << owner_q;
        if (space) in_rdy_o = grant_o;
      end else begin
        grant_o = win_gnt;
        sel_idx = win_idx;
        if (space) in_rdy_o = win_any ? win_gnt : stray;
      end
    end
    sel_flit = in_flit_i[sel_idx*FLIT_W +: FLIT_W];
    sel_type = ftype[sel_idx];
    load     = in_vld_i[sel_idx] && in_rdy_o[sel_idx] && (state_q == ST_LOCKED || win_any);
    drain    = (state_q == ST_IDLE) && !win_any && |(in_vld_i & in_rdy_o);
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    out_flit_d = out_flit_q;
    out_vld_d  = out_vld_q;
    pkt_cnt_d  = pkt_cnt_q;
    err_d      = err_q || drain;

    if (load) begin
      out_flit_d = sel_flit;
      out_vld_d  = 1'b1;
    end else if (out_rdy_i) begin
      out_vld_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          if (sel_type == FT_HEAD) begin
            state_d = ST_LOCKED;
            owner_d = win_idx;
          end else begin
            rr_ptr_d  = inc_wrap(win_idx);
            pkt_cnt_d = pkt_cnt_q + 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (load && (sel_type == FT_TAIL || sel_type == FT_SINGLE)) begin
          state_d   = ST_IDLE;
          rr_ptr_d  = inc_wrap(owner_q);
          pkt_cnt_d = pkt_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      out_flit_q <= '0;
      out_vld_q  <= 1'b0;
      pkt_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      out_flit_q <= out_flit_d;
      out_vld_q  <= out_vld_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_q      <= err_d;
    end
  end

  assign out_flit_o = out_flit_q;
  assign out_vld_o  = out_vld_q;
  assign pkt_cnt_o  = pkt_cnt_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_router_out_arb.sv
// tb/tb_router_out_arb.sv - directed vector bench for router_out_arb
module tb_router_out_arb;

  localparam int NP = 4;
  localparam int FW = 32;
  localparam int CW = 16;
  localparam logic [1:0] H = 2'b01, B = 2'b00, T = 2'b10, S = 2'b11;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NP*FW-1:0] in_flit = '0;
  logic [NP-1:0]  in_vld = '0;
  logic [NP-1:0]  in_rdy;
  logic [FW-1:0]  out_flit;
  logic           out_vld;
  logic           out_rdy = 1'b1;
  logic [NP-1:0]  grant;
  logic [CW-1:0]  pkt_cnt;
  logic           err;

  router_out_arb #(.N_PORTS(NP), .FLIT_W(FW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_flit_i  (in_flit),
    .in_vld_i   (in_vld),
    .in_rdy_o   (in_rdy),
    .out_flit_o (out_flit),
    .out_vld_o  (out_vld),
    .out_rdy_i  (out_rdy),
    .grant_o    (grant),
    .pkt_cnt_o  (pkt_cnt),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        r;
    logic [3:0]  v;
    logic [7:0]  ty;
    logic [7:0]  g;
    logic        ordy;
    logic [3:0]  erdy;
    logic [3:0]  egnt;
    logic        evld;
    logic [31:0] eflit;
    logic [15:0] ecnt;
    logic        eerr;
  } vec_t;

  vec_t tv[$];
  int n_vec  = 0;
  int n_miss = 0;

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [7:0] g, input int p);
    return {t, 14'd0, g, p[7:0]};
  endfunction

  function automatic vec_t mkv(input logic r, input logic [3:0] v, input logic [7:0] ty,
                               input logic [7:0] g, input logic ordy, input logic [3:0] erdy,
                               input logic [3:0] egnt, input logic evld, input logic [31:0] eflit,
                               input logic [15:0] ecnt, input logic eerr);
    vec_t x;
    x.r = r; x.v = v; x.ty = ty; x.g = g; x.ordy = ordy;
    x.erdy = erdy; x.egnt = egnt; x.evld = evld; x.eflit = eflit; x.ecnt = ecnt; x.eerr = eerr;
    return x;
  endfunction

  task automatic drive(input logic r, input logic [3:0] v, input logic [7:0] ty,
                       input logic [7:0] g, input logic ordy);
    rst     = r;
    in_vld  = v;
    out_rdy = ordy;
    for (int k = 0; k < NP; k++) in_flit[k*FW +: FW] = mk(ty[2*k +: 2], g, k);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
      n_miss++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // A: port 0 sends H,B,T
    tv.push_back(mkv(0, 4'b0000, {B,B,B,B}, 8'd0,  1, 4'b0000, 4'b0000, 0, 32'd0,          16'd0, 0));
    tv.push_back(mkv(0, 4'b0001, {B,B,B,H}, 8'd1,  1, 4'b0001, 4'b0001, 0, 32'd0,          16'd0, 0));
    tv.push_back(mkv(0, 4'b0001, {B,B,B,B}, 8'd2,  1, 4'b0001, 4'b0001, 1, mk(H, 8'd1, 0), 16'd0, 0));
    tv.push_back(mkv(0, 4'b0001, {B,B,B,T}, 8'd3,  1, 4'b0001, 4'b0001, 1, mk(B, 8'd2, 0), 16'd0, 0));
    tv.push_back(mkv(0, 4'b0000, {B,B,B,B}, 8'd4,  1, 4'b0000, 4'b0000, 1, mk(T, 8'd3, 0), 16'd1, 0));
    // B: ports 0 and 2 both HEAD out of reset
    tv.push_back(mkv(1, 4'b0101, {B,H,B,H}, 8'd5,  1, 4'b0000, 4'b0000, 0, 32'd0,          16'd1, 0));
    tv.push_back(mkv(0, 4'b0101, {B,H,B,H}, 8'd6,  1, 4'b0001, 4'b0001, 0, 32'd0,          16'd0, 0));
    tv.push_back(mkv(0, 4'b0101, {B,H,B,B}, 8'd7,  1, 4'b0001, 4'b0001, 1, mk(H, 8'd6, 0), 16'd0, 0));
    tv.push_back(mkv(0, 4'b0101, {B,H,B,T}, 8'd8,  1, 4'b0001, 4'b0001, 1, mk(B, 8'd7, 0), 16'd0, 0));
    tv.push_back(mkv(0, 4'b0100, {B,H,B,B}, 8'd9,  1, 4'b0100, 4'b0100, 1, mk(T, 8'd8, 0), 16'd1, 0));
    tv.push_back(mkv(0, 4'b0100, {B,T,B,B}, 8'd10, 1, 4'b0100, 4'b0100, 1, mk(H, 8'd9, 2), 16'd1, 0));
    tv.push_back(mkv(0, 4'b0000, {B,B,B,B}, 8'd11, 1, 4'b0000, 4'b0000, 1, mk(T, 8'd10, 2), 16'd2, 0));
    // C: all ports SINGLE, rr_ptr starts at 3
    tv.push_back(mkv(0, 4'b1111, {S,S,S,S}, 8'd12, 1, 4'b1000, 4'b1000, 0, 32'd0,           16'd2, 0));
    tv.push_back(mkv(0, 4'b1111, {S,S,S,S}, 8'd13, 1, 4'b0001, 4'b0001, 1, mk(S, 8'd12, 3), 16'd3, 0));
    tv.push_back(mkv(0, 4'b1111, {S,S,S,S}, 8'd14, 1, 4'b0010, 4'b0010, 1, mk(S, 8'd13, 0), 16'd4, 0));
    tv.push_back(mkv(0, 4'b1111, {S,S,S,S}, 8'd15, 1, 4'b0100, 4'b0100, 1, mk(S, 8'd14, 1), 16'd5, 0));
    tv.push_back(mkv(0, 4'b1111, {S,S,S,S}, 8'd16, 1, 4'b1000, 4'b1000, 1, mk(S, 8'd15, 2), 16'd6, 0));
    tv.push_back(mkv(0, 4'b0000, {B,B,B,B}, 8'd17, 1, 4'b0000, 4'b0000, 1, mk(S, 8'd16, 3), 16'd7, 0));
    // D: 3-cycle downstream stall mid-packet on port 1
    tv.push_back(mkv(0, 4'b0010, {B,B,H,B}, 8'd18, 1, 4'b0010, 4'b0010, 0, 32'd0,           16'd7, 0));
    tv.push_back(mkv(0, 4'b0010, {B,B,B,B}, 8'd19, 0, 4'b0000, 4'b0010, 1, mk(H, 8'd18, 1), 16'd7, 0));
    tv.push_back(mkv(0, 4'b0010, {B,B,B,B}, 8'd19, 0, 4'b0000, 4'b0010, 1, mk(H, 8'd18, 1), 16'd7, 0));
    tv.push_back(mkv(0, 4'b0010, {B,B,B,B}, 8'd19, 0, 4'b0000, 4'b0010, 1, mk(H, 8'd18, 1), 16'd7, 0));
    tv.push_back(mkv(0, 4'b0010, {B,B,B,B}, 8'd19, 1, 4'b0010, 4'b0010, 1, mk(H, 8'd18, 1), 16'd7, 0));
    tv.push_back(mkv(0, 4'b0010, {B,B,T,B}, 8'd23, 1, 4'b0010, 4'b0010, 1, mk(B, 8'd19, 1), 16'd7, 0));
    tv.push_back(mkv(0, 4'b0000, {B,B,B,B}, 8'd24, 1, 4'b0000, 4'b0000, 1, mk(T, 8'd23, 1), 16'd8, 0));
    // E: stray BODY on port 1 while idle
    tv.push_back(mkv(0, 4'b0010, {B,B,B,B}, 8'd25, 1, 4'b0010, 4'b0000, 0, 32'd0,           16'd8, 0));
    tv.push_back(mkv(0, 4'b0000, {B,B,B,B}, 8'd26, 1, 4'b0000, 4'b0000, 0, 32'd0,           16'd8, 1));
    tv.push_back(mkv(0, 4'b0000, {B,B,B,B}, 8'd27, 1, 4'b0000, 4'b0000, 0, 32'd0,           16'd8, 1));
    // F: reset after HEAD and BODY, then port 3 packet
    tv.push_back(mkv(0, 4'b0001, {B,B,B,H}, 8'd28, 1, 4'b0001, 4'b0001, 0, 32'd0,           16'd8, 1));
    tv.push_back(mkv(0, 4'b0001, {B,B,B,B}, 8'd29, 1, 4'b0001, 4'b0001, 1, mk(H, 8'd28, 0), 16'd8, 1));
    tv.push_back(mkv(1, 4'b0001, {B,B,B,T}, 8'd30, 1, 4'b0000, 4'b0000, 1, mk(B, 8'd29, 0), 16'd8, 1));
    tv.push_back(mkv(0, 4'b0000, {B,B,B,B}, 8'd31, 1, 4'b0000, 4'b0000, 0, 32'd0,           16'd0, 0));
    tv.push_back(mkv(0, 4'b1000, {H,B,B,B}, 8'd32, 1, 4'b1000, 4'b1000, 0, 32'd0,           16'd0, 0));
    tv.push_back(mkv(0, 4'b0000, {B,B,B,B}, 8'd33, 1, 4'b1000, 4'b1000, 1, mk(H, 8'd32, 3), 16'd0, 0));
    tv.push_back(mkv(0, 4'b1000, {T,B,B,B}, 8'd34, 1, 4'b1000, 4'b1000, 0, 32'd0,           16'd0, 0));
    tv.push_back(mkv(0, 4'b0000, {B,B,B,B}, 8'd35, 1, 4'b0000, 4'b0000, 1, mk(T, 8'd34, 3), 16'd1, 0));

    drive(1, 4'b0000, 8'd0, 8'd0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(0, 4'b0000, 8'd0, 8'd0, 1'b1);
    #1;
    n_vec++;
    chk("reset_out_flit", -1, out_flit, 32'd0);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i].r, tv[i].v, tv[i].ty, tv[i].g, tv[i].ordy);
      #1;
      n_vec++;
      chk("in_rdy",  i, 32'(in_rdy),  32'(tv[i].erdy));
      chk("grant",   i, 32'(grant),   32'(tv[i].egnt));
      chk("out_vld", i, 32'(out_vld), 32'(tv[i].evld));
      chk("pkt_cnt", i, 32'(pkt_cnt), 32'(tv[i].ecnt));
      chk("err",     i, 32'(err),     32'(tv[i].eerr));
      if (tv[i].evld) chk("out_flit", i, out_flit, tv[i].eflit);
    end

    // G: SINGLE from port 2 loaded while downstream is not ready, then held
    begin
      int w;
      @(negedge clk);
      drive(0, 4'b0100, {B,S,B,B}, 8'h40, 1'b0);
      #1;
      w = 0;
      while (!in_rdy[2] && w < 5) begin
        @(negedge clk);
        #1;
        w++;
      end
      n_vec++;
      chk("single_accept_timeout", w, 32'(in_rdy[2]), 32'd1);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        drive(0, 4'b0001, {B,B,B,H}, 8'h41, 1'b0);
        #1;
        n_vec++;
        chk("hold_vld",   100 + c, 32'(out_vld),  32'd1);
        chk("hold_flit",  100 + c, out_flit,      mk(S, 8'h40, 2));
        chk("hold_rdy",   100 + c, 32'(in_rdy),   32'd0);
        chk("hold_grant", 100 + c, 32'(grant),    32'b0001);
        chk("hold_cnt",   100 + c, 32'(pkt_cnt),  32'd2);
      end
      @(negedge clk);
      drive(0, 4'b0000, 8'd0, 8'd0, 1'b1);
      @(negedge clk);
      #1;
      n_vec++;
      chk("release_vld", 200, 32'(out_vld), 32'd0);
      chk("release_cnt", 200, 32'(pkt_cnt), 32'd2);
      chk("release_err", 200, 32'(err),     32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
